// File: rtl/l1_refill_arbiter_if.sv
// ---------------------------------------------------------------------------
// l1_refill_arbiter_if
// Bundle of every handshake signal around the refill arbiter: the two L1
// request/response channels (c0_*, c1_*) and the shared memory port (mem_*).
//   slave  : arbiter view (takes L1 requests, answers them, drives memory)
//   master : environment view (the two L1s plus the data memory)
// Parameters: ADDR_W address width, DATA_W data word width.
// ---------------------------------------------------------------------------
interface l1_refill_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   // core0 channel
   logic              c0_req;
   logic              c0_we;
   logic [ADDR_W-1:0] c0_addr;
   logic [DATA_W-1:0] c0_wdata;
   logic              c0_ack;
   logic [DATA_W-1:0] c0_rdata;
   logic              c0_err;
   // core1 channel
   logic              c1_req;
   logic              c1_we;
   logic [ADDR_W-1:0] c1_addr;
   logic [DATA_W-1:0] c1_wdata;
   logic              c1_ack;
   logic [DATA_W-1:0] c1_rdata;
   logic              c1_err;
   // shared memory port
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  c0_req, c0_we, c0_addr, c0_wdata,
      output c0_ack, c0_rdata, c0_err,
      input  c1_req, c1_we, c1_addr, c1_wdata,
      output c1_ack, c1_rdata, c1_err,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport master (
      output c0_req, c0_we, c0_addr, c0_wdata,
      input  c0_ack, c0_rdata, c0_err,
      output c1_req, c1_we, c1_addr, c1_wdata,
      input  c1_ack, c1_rdata, c1_err,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/l1_refill_arbiter.sv
// ---------------------------------------------------------------------------
// l1_refill_arbiter
// Shares one data-memory port between the L1 caches of two cores. One access
// is outstanding at a time; simultaneous requests are served round-robin.
// The owning L1 gets a one-cycle ack carrying the read word (0 for writes)
// and an error flag that is set when memory fails to answer within TIMEOUT
// cycles.
// Ports:
//   clk    clock, all logic on posedge
//   reset  synchronous, active-high; abandons any access without an ack
//   bus    l1_refill_arbiter_if.slave: c0_*/c1_* L1 channels, mem_* port
// Parameters: ADDR_W, DATA_W (must match the interface), TIMEOUT (>= 2).
// ---------------------------------------------------------------------------
module l1_refill_arbiter #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               reset,
   l1_refill_arbiter_if.slave bus
);
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_reg;
   logic              rr_reg;         // core preferred when both request
   logic              owner_reg;      // core that owns the current access
   logic [CNT_W-1:0]  cnt_reg;        // cycles spent waiting in BUSY
   logic              mem_req_reg;
   logic              mem_we_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_wdata_reg;
   logic [1:0]        ack_reg;
   logic [1:0]        err_reg;
   logic [DATA_W-1:0] rdata_reg [2];

   logic [1:0]        req_vec;
   logic              grant_next;
   logic              we_next;
   logic [ADDR_W-1:0] addr_next;
   logic [DATA_W-1:0] wdata_next;

   assign req_vec = {bus.c1_req, bus.c0_req};

   // A lone requester wins regardless of rr; rr only breaks ties.
   always_comb begin
      grant_next = rr_reg;
      if (req_vec == 2'b01) begin
         grant_next = 1'b0;
      end else if (req_vec == 2'b10) begin
         grant_next = 1'b1;
      end
      we_next    = grant_next ? bus.c1_we    : bus.c0_we;
      addr_next  = grant_next ? bus.c1_addr  : bus.c0_addr;
      wdata_next = grant_next ? bus.c1_wdata : bus.c0_wdata;
   end

   // The mem_* registers double as the latched transaction: they are loaded
   // on grant, held through BUSY and cleared when the access finishes, so
   // later changes on the L1 side cannot disturb an access in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         rr_reg        <= 1'b0;
         owner_reg     <= 1'b0;
         cnt_reg       <= '0;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         ack_reg       <= '0;
         err_reg       <= '0;
         for (int i = 0; i < 2; i++) begin
            rdata_reg[i] <= '0;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (|req_vec) begin
                  owner_reg     <= grant_next;
                  mem_req_reg   <= 1'b1;
                  mem_we_reg    <= we_next;
                  mem_addr_reg  <= addr_next;
                  mem_wdata_reg <= wdata_next;
                  cnt_reg       <= '0;
                  state_reg     <= BUSY;
               end
            end
            BUSY: begin
               // mem_ready wins over a timeout expiring on the same edge.
               if (bus.mem_ready || (cnt_reg == CNT_LAST)) begin
                  ack_reg[owner_reg]   <= 1'b1;
                  err_reg[owner_reg]   <= ~bus.mem_ready;
                  rdata_reg[owner_reg] <= (bus.mem_ready && !mem_we_reg) ? bus.mem_rdata : '0;
                  mem_req_reg          <= 1'b0;
                  mem_we_reg           <= 1'b0;
                  mem_addr_reg         <= '0;
                  mem_wdata_reg        <= '0;
                  state_reg            <= RESP;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            RESP: begin
               ack_reg   <= '0;
               err_reg   <= '0;
               for (int i = 0; i < 2; i++) begin
                  rdata_reg[i] <= '0;
               end
               rr_reg    <= ~owner_reg;
               cnt_reg   <= '0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_req   = mem_req_reg;
   assign bus.mem_we    = mem_we_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;
   assign bus.c0_ack    = ack_reg[0];
   assign bus.c0_err    = err_reg[0];
   assign bus.c0_rdata  = rdata_reg[0];
   assign bus.c1_ack    = ack_reg[1];
   assign bus.c1_err    = err_reg[1];
   assign bus.c1_rdata  = rdata_reg[1];
endmodule

// File: tb/tb_l1_refill_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l1_refill_arbiter
// Directed bench for l1_refill_arbiter. A transaction-level model predicts
// every output each cycle; directed tests add hand-computed literal checks
// for latency, data, arbitration order, timeout and reset behaviour.
// ---------------------------------------------------------------------------
module tb_l1_refill_arbiter;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   l1_refill_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   l1_refill_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int asserts  = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // ---------------- memory responder ----------------
   logic [31:0] mem_arr [0:1023];
   int          mem_wait = 0;     // wait cycles before ready, -1 = never
   int          mcnt     = 0;
   logic        ready_drv  = 1'b0;
   logic        stray_ready = 1'b0;
   assign bus.mem_ready = ready_drv | stray_ready;

   initial begin
      for (int i = 0; i < 1024; i++) mem_arr[i] = 32'hA500_0000 | i;
      mem_arr[10'h104] = 32'hDEAD_BEEF;
      bus.mem_rdata = 32'h0BAD_0BAD;
      forever begin
         @(posedge clk); #1;
         if (!bus.mem_req || ready_drv) begin
            ready_drv     = 1'b0;
            mcnt          = 0;
            bus.mem_rdata = 32'h0BAD_0BAD;
         end else begin
            if (mem_wait >= 0 && mcnt == mem_wait) begin
               ready_drv = 1'b1;
               if (bus.mem_we) begin
                  bus.mem_rdata = 32'hFFFF_FFFF;
                  mem_arr[bus.mem_addr] = bus.mem_wdata;
               end else begin
                  bus.mem_rdata = mem_arr[bus.mem_addr];
               end
            end
            mcnt++;
         end
      end
   end

   // ---------------- transaction-level model ----------------
   logic        m_busy = 0, m_we = 0, m_owner = 0, m_pref = 0;
   logic [9:0]  m_addr = 0;
   logic [31:0] m_wdata = 0;
   int          m_age = 0;
   logic        m_resp = 0, m_rowner = 0, m_rerr = 0;
   logic [31:0] m_rdata = 0;

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            m_busy = 0; m_resp = 0; m_pref = 0;
         end else if (m_resp) begin
            m_resp = 0;
            m_pref = ~m_rowner;
         end else if (m_busy) begin
            m_age++;
            if (bus.mem_ready) begin
               m_resp = 1; m_rowner = m_owner; m_rerr = 0;
               m_rdata = m_we ? 32'd0 : bus.mem_rdata;
               m_busy = 0;
            end else if (m_age == TIMEOUT) begin
               m_resp = 1; m_rowner = m_owner; m_rerr = 1; m_rdata = 0;
               m_busy = 0;
            end
         end else if (bus.c0_req || bus.c1_req) begin
            m_owner = (bus.c0_req && bus.c1_req) ? m_pref : bus.c1_req;
            m_we    = m_owner ? bus.c1_we    : bus.c0_we;
            m_addr  = m_owner ? bus.c1_addr  : bus.c0_addr;
            m_wdata = m_owner ? bus.c1_wdata : bus.c0_wdata;
            m_busy  = 1;
            m_age   = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [111:0] exp_vec, act_vec;
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            exp_vec = {m_busy, m_busy & m_we,
                       m_busy ? m_addr : 10'd0, m_busy ? m_wdata : 32'd0,
                       m_resp & ~m_rowner, (m_resp & ~m_rowner) ? m_rerr : 1'b0,
                       (m_resp & ~m_rowner) ? m_rdata : 32'd0,
                       m_resp & m_rowner, (m_resp & m_rowner) ? m_rerr : 1'b0,
                       (m_resp & m_rowner) ? m_rdata : 32'd0};
            act_vec = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                       bus.c0_ack, bus.c0_err, bus.c0_rdata,
                       bus.c1_ack, bus.c1_err, bus.c1_rdata};
            asserts++;
            if (act_vec !== exp_vec) begin
               failures++;
               $display("FAIL cycle_model @%0t: got %h expected %h", $time, act_vec, exp_vec);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   task automatic set_req(input bit core, input logic we, input logic [9:0] addr, input logic [31:0] wd);
      if (core) begin
         bus.c1_req = 1; bus.c1_we = we; bus.c1_addr = addr; bus.c1_wdata = wd;
      end else begin
         bus.c0_req = 1; bus.c0_we = we; bus.c0_addr = addr; bus.c0_wdata = wd;
      end
   endtask

   // Wait (bounded) for this core's ack; k = edges since call, km = first edge mem_req seen high.
   task automatic wait_ack(input string name, input bit core, input int limit,
                           output int k, output int km, output logic [31:0] rd,
                           output logic er, output logic oth);
      bit got = 0;
      k = 0; km = -1; rd = 0; er = 0; oth = 0;
      while (k < limit && !got) begin
         tick(); k++;
         if (km < 0 && bus.mem_req) km = k;
         if (core ? bus.c1_ack : bus.c0_ack) got = 1;
      end
      rd  = core ? bus.c1_rdata : bus.c0_rdata;
      er  = core ? bus.c1_err   : bus.c0_err;
      oth = core ? bus.c0_ack   : bus.c1_ack;
      asserts++;
      if (!got) begin
         failures++;
         $display("FAIL %s_ack: got no ack expected ack within %0d cycles", name, limit);
      end else begin
         $display("ack  %s after %0d cycles rdata=%h err=%0b", name, k, rd, er);
      end
   endtask

   // The requester lowers req on the edge that ends its ack cycle.
   task automatic drop(input bit core);
      tick();
      if (core) bus.c1_req = 0; else bus.c0_req = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   int k, km, acks_seen;
   logic [31:0] rd;
   logic er, oth;

   initial begin
      reset = 1;
      bus.c0_req = 0; bus.c0_we = 0; bus.c0_addr = 0; bus.c0_wdata = 0;
      bus.c1_req = 0; bus.c1_we = 0; bus.c1_addr = 0; bus.c1_wdata = 0;
      tick();
      chk_en = 1;

      // 1: reset held 3 cycles with c0 requesting
      set_req(0, 0, 10'h010, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_quiet", {29'd0, bus.mem_req, bus.c0_ack, bus.c1_ack}, 32'd0);
      end
      reset = 0;
      tick();
      check("post_reset_grant_req", {31'd0, bus.mem_req}, 32'd1);
      check("post_reset_grant_addr", {22'd0, bus.mem_addr}, 32'h010);
      wait_ack("t1_c0", 0, 10, k, km, rd, er, oth);
      check("t1_rdata", rd, 32'hA500_0010);
      drop(0);

      // 4: c1 write, zero-wait memory
      mem_wait = 0;
      set_req(1, 1, 10'h3FC, 32'h55AA_00FF);
      tick();
      check("t4_mem_we", {31'd0, bus.mem_we}, 32'd1);
      check("t4_mem_addr", {22'd0, bus.mem_addr}, 32'h3FC);
      check("t4_mem_wdata", bus.mem_wdata, 32'h55AA_00FF);
      tick();
      check("t4_c1_ack_at_2", {31'd0, bus.c1_ack}, 32'd1);
      check("t4_c1_rdata", bus.c1_rdata, 32'd0);
      check("t4_c0_ack", {31'd0, bus.c0_ack}, 32'd0);
      drop(1);

      // 3a: contention with rr=0 -> c0 then c1
      mem_wait = 1;
      set_req(0, 0, 10'h020, 0);
      set_req(1, 0, 10'h030, 0);
      wait_ack("t3a_first_c0", 0, 10, k, km, rd, er, oth);
      check("t3a_c0_rdata", rd, 32'hA500_0020);
      check("t3a_c1_quiet", {31'd0, oth}, 32'd0);
      drop(0);
      wait_ack("t3a_second_c1", 1, 10, k, km, rd, er, oth);
      check("t3a_c1_rdata", rd, 32'hA500_0030);
      drop(1);

      // 2: single c0 read with 3 wait cycles
      mem_wait = 3;
      set_req(0, 0, 10'h104, 0);
      wait_ack("t2_c0", 0, 20, k, km, rd, er, oth);
      check("t2_latency", k, 32'd5);
      check("t2_rdata", rd, 32'hDEAD_BEEF);
      check("t2_err", {31'd0, er}, 32'd0);
      check("t2_c1_quiet", {31'd0, oth}, 32'd0);
      drop(0);

      // 3b: rr=1 -> c1 first, then alternation with both held
      mem_wait = 0;
      set_req(0, 0, 10'h040, 0);
      set_req(1, 0, 10'h050, 0);
      wait_ack("t3b_first_c1", 1, 10, k, km, rd, er, oth);
      check("t3b_c1_rdata", rd, 32'hA500_0050);
      check("t3b_c0_quiet", {31'd0, oth}, 32'd0);
      tick();
      set_req(1, 0, 10'h060, 0);
      wait_ack("t3b_then_c0", 0, 10, k, km, rd, er, oth);
      check("t3b_c0_rdata", rd, 32'hA500_0040);
      drop(0);
      wait_ack("t3b_then_c1", 1, 10, k, km, rd, er, oth);
      check("t3b_c1b_rdata", rd, 32'hA500_0060);
      drop(1);

      // stray mem_ready while idle must be ignored
      stray_ready = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stray_ready_idle", {30'd0, bus.mem_req, bus.c0_ack | bus.c1_ack}, 32'd0);
      end
      stray_ready = 0;

      // 5: timeout
      mem_wait = -1;
      set_req(0, 0, 10'h070, 0);
      wait_ack("t5_c0", 0, TIMEOUT + 20, k, km, rd, er, oth);
      check("t5_timeout_distance", k - km, TIMEOUT);
      check("t5_err", {31'd0, er}, 32'd1);
      check("t5_rdata", rd, 32'd0);
      check("t5_mem_req_low", {31'd0, bus.mem_req}, 32'd0);
      drop(0);

      // 6: reset mid-BUSY (rr=1 before reset)
      set_req(0, 0, 10'h080, 0);
      for (int i = 0; i < 5; i++) tick();
      reset = 1;
      tick();
      check("t6_mem_req_after_reset", {31'd0, bus.mem_req}, 32'd0);
      reset = 0;
      bus.c0_req = 0;
      acks_seen = 0;
      for (int i = 0; i < TIMEOUT + 6; i++) begin
         tick();
         if (bus.c0_ack || bus.c1_ack) acks_seen++;
      end
      check("t6_no_ack", acks_seen, 32'd0);
      mem_wait = 1;
      set_req(0, 0, 10'h090, 0);
      set_req(1, 0, 10'h0A0, 0);
      wait_ack("t6_c0_first", 0, 10, k, km, rd, er, oth);
      check("t6_c0_rdata", rd, 32'hA500_0090);
      drop(0);
      wait_ack("t6_c1", 1, 10, k, km, rd, er, oth);
      check("t6_c1_rdata", rd, 32'hA500_00A0);
      drop(1);

      for (int i = 0; i < 4; i++) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end
endmodule
